// File: rtl/encoder83_irq.sv
// Sticky 8-line interrupt request encoder: captures active-low requests into a
// pending register and presents one fixed-priority code at a time until acknowledged.
module encoder83_irq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [7:0] I_n,
  input  logic       ack,
  output logic [2:0] A,
  output logic       valid,
  output logic       GS_n,
  output logic [7:0] pend
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [7:0] pend_reg;
  logic [7:0] pend_next;
  logic [2:0] a_reg;
  logic       valid_reg;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  function automatic logic [2:0] prio_idx(input logic [7:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    // Later matches overwrite earlier ones, so scan order sets the winner.
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (p[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (p[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Set is applied after clear so a request sampled on its own ack edge survives.
  always_comb begin
    set_mask  = E ? ~I_n : 8'h00;
    clr_mask  = (state_reg == PRESENT && ack) ? (8'h01 << a_reg) : 8'h00;
    pend_next = (pend_reg & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= 8'h00;
      a_reg     <= 3'd0;
      valid_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      case (state_reg)
        IDLE: begin
          if (|pend_reg) begin
            state_reg <= PRESENT;
            a_reg     <= prio_idx(pend_reg);
            valid_reg <= 1'b1;
          end
        end
        PRESENT: begin
          if (ack) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign A     = a_reg;
  assign valid = valid_reg;
  assign pend  = pend_reg;
  assign GS_n  = ~|pend_reg;

endmodule

// File: tb/tb_encoder83_irq.sv
// Directed table-driven bench for encoder83_irq, high-first and low-first instances.
module tb_encoder83_irq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       E = 1'b0;
  logic [7:0] I_n = 8'hFF;
  logic       ack = 1'b0;

  logic [2:0] a_h, a_l;
  logic       valid_h, valid_l, gs_n_h, gs_n_l;
  logic [7:0] pend_h, pend_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder83_irq #(.HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .E(E), .I_n(I_n), .ack(ack),
    .A(a_h), .valid(valid_h), .GS_n(gs_n_h), .pend(pend_h)
  );

  encoder83_irq #(.HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .E(E), .I_n(I_n), .ack(ack),
    .A(a_l), .valid(valid_l), .GS_n(gs_n_l), .pend(pend_l)
  );

  typedef struct {
    logic       rst;
    logic       e;
    logic [7:0] i_n;
    logic       ack;
    logic [7:0] pend;
    logic [2:0] a;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic e, input logic [7:0] i_n, input logic ak,
                     input logic [7:0] p, input logic [2:0] a, input logic v);
    vec_t t;
    t.rst = rst; t.e = e; t.i_n = i_n; t.ack = ak; t.pend = p; t.a = a; t.valid = v;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0; E = 1'b0; I_n = 8'hFF; ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic e, input logic [7:0] i_n, input logic ak);
    E = e; I_n = i_n; ack = ak;
    @(posedge clk); #1;
  endtask

  initial begin
    // Two lines pulsed, served high-first, then a higher request during PRESENT.
    add(1, 1, 8'hDB, 0, 8'h24, 3'd0, 0);
    add(0, 1, 8'hFF, 0, 8'h24, 3'd5, 1);
    add(0, 1, 8'hFF, 1, 8'h04, 3'd5, 0);
    add(0, 1, 8'hFF, 0, 8'h04, 3'd2, 1);
    add(0, 1, 8'hFF, 1, 8'h00, 3'd2, 0);
    add(0, 1, 8'hFB, 0, 8'h04, 3'd2, 0);
    add(0, 1, 8'hFF, 0, 8'h04, 3'd2, 1);
    add(0, 1, 8'hBF, 0, 8'h44, 3'd2, 1);
    add(0, 1, 8'hFF, 0, 8'h44, 3'd2, 1);
    add(0, 1, 8'hFF, 1, 8'h40, 3'd2, 0);
    add(0, 1, 8'hFF, 0, 8'h40, 3'd6, 1);
    add(0, 1, 8'hFF, 1, 8'h00, 3'd6, 0);
    // Enable low blocks capture, then one enabled cycle captures all lines.
    for (int k = 0; k < 5; k++) add(0, 0, 8'h00, 0, 8'h00, 3'd6, 0);
    add(0, 1, 8'h00, 0, 8'hFF, 3'd6, 0);
    add(0, 0, 8'hFF, 0, 8'hFF, 3'd7, 1);
    add(0, 0, 8'hFF, 1, 8'h7F, 3'd7, 0);
    add(0, 0, 8'hFF, 0, 8'h7F, 3'd6, 1);
    add(0, 0, 8'hFF, 1, 8'h3F, 3'd6, 0);
    // ack while idle must not clear anything.
    add(0, 0, 8'hFF, 1, 8'h3F, 3'd5, 1);
    // Request held through its own ack edge: set wins, code re-presented.
    add(1, 1, 8'hF7, 0, 8'h08, 3'd0, 0);
    add(0, 1, 8'hF7, 0, 8'h08, 3'd3, 1);
    add(0, 1, 8'hF7, 1, 8'h08, 3'd3, 0);
    add(0, 1, 8'hFF, 0, 8'h08, 3'd3, 1);
    add(0, 1, 8'hFF, 1, 8'h00, 3'd3, 0);

    // Asynchronous reset state at time zero.
    #2;
    check("rst_pend", pend_h, 8'h00);
    check("rst_a", {5'd0, a_h}, 8'd0);
    check("rst_valid", {7'd0, valid_h}, 8'd0);
    check("rst_gs_n", {7'd0, gs_n_h}, 8'd1);

    // Requests held during reset are not captured.
    E = 1'b1; I_n = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_hold_pend", pend_h, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_pend", pend_h, 8'hFF);
    $display("txn reset-hold: pend=%02h", pend_h);

    @(posedge clk); #1;
    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      step(vecs[n].e, vecs[n].i_n, vecs[n].ack);
      check($sformatf("v%0d_pend", n), pend_h, vecs[n].pend);
      check($sformatf("v%0d_a", n), {5'd0, a_h}, {5'd0, vecs[n].a});
      check($sformatf("v%0d_valid", n), {7'd0, valid_h}, {7'd0, vecs[n].valid});
      check($sformatf("v%0d_gs_n", n), {7'd0, gs_n_h}, {7'd0, vecs[n].pend == 8'h00});
      $display("txn v%0d: E=%b I_n=%02h ack=%b -> pend=%02h A=%0d valid=%b GS_n=%b",
               n, vecs[n].e, vecs[n].i_n, vecs[n].ack, pend_h, a_h, valid_h, gs_n_h);
    end

    // Low-first instance: lines 0 and 7 served 0 then 7.
    do_reset();
    step(1, 8'h7E, 0);
    check("lo_pend", pend_l, 8'h81);
    step(1, 8'hFF, 0);
    check("lo_first_a", {5'd0, a_l}, 8'd0);
    check("lo_first_valid", {7'd0, valid_l}, 8'd1);
    step(1, 8'hFF, 1);
    check("lo_ack_valid", {7'd0, valid_l}, 8'd0);
    step(1, 8'hFF, 0);
    check("lo_second_a", {5'd0, a_l}, 8'd7);
    check("lo_second_valid", {7'd0, valid_l}, 8'd1);
    $display("txn low-first: A=%0d valid=%b pend=%02h", a_l, valid_l, pend_l);

    // Mid-cycle asynchronous reset while presenting.
    do_reset();
    step(1, 8'h6F, 0);
    step(1, 8'hFF, 0);
    check("async_pre_pend", pend_h, 8'h90);
    check("async_pre_a", {5'd0, a_h}, 8'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pend", pend_h, 8'h00);
    check("async_valid", {7'd0, valid_h}, 8'd0);
    check("async_gs_n", {7'd0, gs_n_h}, 8'd1);
    check("async_a", {5'd0, a_h}, 8'd0);
    $display("txn async-reset: pend=%02h A=%0d valid=%b GS_n=%b", pend_h, a_h, valid_h, gs_n_h);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder83_irq.md
ENCODER83_IRQ -- requirements
Module: encoder83_irq

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 1, meaning: 1 = line 7 highest priority, 0 = line 0 highest priority.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port E  input  1  enable, active-high; gates capture of new requests only.
REQ-005 SHALL have port I_n  input  8  request lines, active-low, bit i = request line i.
REQ-006 SHALL have port ack  input  1  consumer acknowledge of the presented code, active-high.
REQ-007 SHALL have port A  output  3  registered binary code of the presented line (A[0] LSB).
REQ-008 SHALL have port valid  output  1  registered; high while A holds a code awaiting ack.
REQ-009 SHALL have port GS_n  output  1  group select, active-low; low when any request is pending.
REQ-010 SHALL have port pend  output  8  pending-request register, bit i = line i pending.

Function
REQ-011 SHALL sample I_n every rising edge; when E=1, each bit with I_n[i]=0 SHALL set pend[i] at that edge (sticky, level-sampled).
REQ-012 SHALL NOT set any pend bit while E=0; already-pending bits SHALL still be served.
REQ-013 SHALL implement a two-state FSM: IDLE (valid=0) and PRESENT (valid=1).
REQ-014 IDLE -> PRESENT at an edge where pend (register value before the edge) is nonzero; A SHALL load the index of the highest-priority set pend bit per HIGH_FIRST.
REQ-015 Latency: request sampled at edge k -> pend set after edge k -> valid=1 and A valid after edge k+1.
REQ-016 In PRESENT, A and valid SHALL hold stable until ack; a higher-priority request arriving meanwhile SHALL only set its pend bit, not alter A.
REQ-017 PRESENT with ack=1 at an edge: pend[A] SHALL clear, valid SHALL drop to 0, FSM SHALL return to IDLE (one IDLE cycle minimum between codes).
REQ-018 If line A's request is sampled (E=1, I_n[A]=0) at the same edge as its ack, set SHALL win: pend[A] stays 1 and is re-presented later.
REQ-019 ack while IDLE SHALL be ignored (no pend change).
REQ-020 GS_n SHALL equal ~|pend combinationally from the pend register.
REQ-021 A SHALL hold its last value in IDLE; consumers use A only while valid=1.
REQ-022 Priority select SHALL be a fixed priority encoder over pend; no round-robin or fairness.

Reset
REQ-023 rst_n=0 SHALL immediately, without clk, force pend=8'h00, A=3'd0, valid=0, GS_n=1, FSM=IDLE.
REQ-024 Requests held active during reset SHALL NOT be captured; capture begins at the first rising edge with rst_n=1.
REQ-025 Reset asserted in PRESENT SHALL discard the presented code and all pending bits.

Verification
REQ-026 HIGH_FIRST=1, E=1, I_n=8'hDB (lines 2,5) pulsed one cycle -> pend=8'h24, GS_n=0; next edge A=5, valid=1; ack -> A=2, valid=1 after one IDLE cycle; ack -> pend=0, GS_n=1.
REQ-027 HIGH_FIRST=0, I_n=8'h7E (lines 0,7) -> first A=0, then A=7 after ack.
REQ-028 A=2 presented, line 6 requested before ack -> A stays 2 until ack, then A=6 presented.
REQ-029 E=0, I_n=8'h00 for 5 cycles -> pend stays 0, valid stays 0; E=1 one cycle -> pend=8'hFF, A=7.
REQ-030 A=3 presented, I_n[3]=0 held through ack edge -> pend[3] remains 1, A=3 re-presented after one IDLE cycle.
REQ-031 rst_n pulled low mid-cycle during PRESENT with pend=8'h90 -> outputs reset asynchronously before next clk edge: pend=0, valid=0, GS_n=1, A=0.
